// File: rtl/ob_drain_serializer.sv
// ob_drain_serializer: drains rows of an output buffer and serializes each row lane-by-lane onto a valid/ready stream.
// Optional feature macro: OB_DRAIN_CHECKSUM_EN adds checksum_o (running sum of transferred elements).
// Ports:
//   clk_i, rstn_async_i           clock, asynchronous active-low reset
//   start_i, base_addr_i, num_rows_i  drain request, first row, row count (sampled in IDLE only)
//   ob_mem_cenb_o/wenb_o/addr_o   read-only memory port (active-low enables), one-cycle read latency
//   ob_mem_data_i                 row read data, lane 0 in the LSBs
//   data_o, valid_o, ready_i, last_o  element stream
//   busy_o, done_o                status, done_o pulses one cycle at the end of a drain
module ob_drain_serializer #(
  parameter int WIDTH  = 16,
  parameter int COL    = 4,
  parameter int O_SIZE = 256,
  localparam int AW = $clog2(O_SIZE),
  localparam int CW = AW + 1,
  localparam int LW = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_async_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [CW-1:0]        num_rows_i,
  output logic                 ob_mem_cenb_o,
  output logic                 ob_mem_wenb_o,
  output logic [AW-1:0]        ob_mem_addr_o,
  input  logic [COL*WIDTH-1:0] ob_mem_data_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 busy_o,
`ifdef OB_DRAIN_CHECKSUM_EN
  output logic [WIDTH-1:0]     checksum_o,
`endif
  output logic                 done_o
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] base_q;
  logic [CW-1:0] nrows_q, row_cnt_q;
  logic [LW-1:0] lane_q;
  logic [COL-1:0][WIDTH-1:0] row_q;
  logic xfer, lane_last, last_row, accept;
  assign accept    = (state_q == IDLE) && start_i;
  assign xfer      = valid_o && ready_i;
  assign lane_last = lane_q == LW'(COL - 1);
  assign last_row  = row_cnt_q == nrows_q - CW'(1);
  // Address wraps naturally because O_SIZE is a power of two.
  assign ob_mem_addr_o = base_q + row_cnt_q[AW-1:0];
  assign ob_mem_cenb_o = state_q != READ;
  assign ob_mem_wenb_o = 1'b1;
  assign valid_o       = state_q == EMIT;
  assign data_o        = row_q[lane_q];
  assign last_o        = valid_o && lane_last && last_row;
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? ((num_rows_i == '0) ? DONE : READ) : IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = EMIT;
      EMIT:    state_d = (xfer && lane_last) ? (last_row ? DONE : READ) : EMIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      nrows_q   <= '0;
      row_cnt_q <= '0;
      lane_q    <= '0;
      row_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q    <= base_addr_i;
        nrows_q   <= num_rows_i;
        row_cnt_q <= '0;
      end
      if (state_q == CAPTURE) begin
        row_q  <= ob_mem_data_i;
        lane_q <= '0;
      end
      if (xfer) begin
        lane_q <= lane_q + LW'(1);
        if (lane_last) row_cnt_q <= row_cnt_q + CW'(1);
      end
    end
  end
`ifdef OB_DRAIN_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) checksum_o <= '0;
    else if (accept) checksum_o <= '0;
    else if (xfer) checksum_o <= checksum_o + data_o;
  end
`endif
endmodule

// File: tb/tb_ob_drain_serializer.sv
// tb_ob_drain_serializer: directed self-checking bench for ob_drain_serializer with a one-cycle-latency memory model.
module tb_ob_drain_serializer;
  logic        clk_i = 1'b0;
  logic        rstn_async_i;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic [8:0]  num_rows_i;
  logic        ob_mem_cenb_o, ob_mem_wenb_o;
  logic [7:0]  ob_mem_addr_o;
  logic [63:0] ob_mem_data_i;
  logic [15:0] data_o;
  logic        valid_o, ready_i, last_o, busy_o, done_o;
`ifdef OB_DRAIN_CHECKSUM_EN
  logic [15:0] checksum_o;
`endif
  logic [63:0] mem [256];
  int checks = 0;
  int failures = 0;

  ob_drain_serializer dut (
    .clk_i(clk_i), .rstn_async_i(rstn_async_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_rows_i(num_rows_i),
    .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o),
    .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_i(ob_mem_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o),
`ifdef OB_DRAIN_CHECKSUM_EN
    .checksum_o(checksum_o),
`endif
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (!ob_mem_cenb_o) ob_mem_data_i <= mem[ob_mem_addr_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cenb"}, ob_mem_cenb_o, 1);
    chk({tag, "_wenb"}, ob_mem_wenb_o, 1);
    chk({tag, "_addr"}, ob_mem_addr_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  task automatic run_basic(input string tag);
    start_i = 1; base_addr_i = 5; num_rows_i = 1; ready_i = 1;
    tick();
    start_i = 0;
    chk({tag, "_rd_cenb"}, ob_mem_cenb_o, 0);
    chk({tag, "_rd_addr"}, ob_mem_addr_o, 5);
    chk({tag, "_rd_valid"}, valid_o, 0);
    chk({tag, "_rd_busy"}, busy_o, 1);
    tick();
    chk({tag, "_cap_cenb"}, ob_mem_cenb_o, 1);
    chk({tag, "_cap_valid"}, valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_em_valid"}, valid_o, 1);
      chk({tag, "_em_data"}, data_o, i + 1);
      chk({tag, "_em_last"}, last_o, (i == 3) ? 1 : 0);
      chk({tag, "_em_cenb"}, ob_mem_cenb_o, 1);
    end
    tick();
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_done_valid"}, valid_o, 0);
`ifdef OB_DRAIN_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum_o, 32'h000A);
`endif
    tick();
    chk({tag, "_done_clr"}, done_o, 0);
    chk({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin
    int n, ndone, naddr;
    logic [7:0] exp_addr [3];
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < 4; i++) mem[a][i*16 +: 16] = 16'(a * 256 + i);
    mem[5] = 64'h0004_0003_0002_0001;
    rstn_async_i = 0; start_i = 0; base_addr_i = 0; num_rows_i = 0; ready_i = 1;
    tick(); tick();
    chk_reset_outputs("rst");
    rstn_async_i = 1;
    tick();

    run_basic("basic");

    start_i = 1; base_addr_i = 5; num_rows_i = 1; ready_i = 1;
    tick();
    start_i = 0;
    tick();
    tick();
    chk("bp_d0", data_o, 1);
    start_i = 1; base_addr_i = 9; num_rows_i = 3;
    tick();
    start_i = 0;
    chk("bp_d1", data_o, 2);
    ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_data", data_o, 2);
      chk("bp_hold_last", last_o, 0);
    end
    ready_i = 1;
    tick();
    chk("bp_d2", data_o, 3);
    tick();
    chk("bp_d3", data_o, 4);
    chk("bp_d3_last", last_o, 1);
    tick();
    chk("bp_done", done_o, 1);
    tick();
    chk("bp_idle", busy_o, 0);

    exp_addr[0] = 254; exp_addr[1] = 255; exp_addr[2] = 0;
    n = 0; ndone = 0; naddr = 0;
    start_i = 1; base_addr_i = 254; num_rows_i = 3; ready_i = 1;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      tick();
      start_i = 0;
      if (!ob_mem_cenb_o) begin
        if (naddr < 3) chk("wrap_addr", ob_mem_addr_o, exp_addr[naddr]);
        naddr++;
      end
      if (valid_o && ready_i) begin
        chk("wrap_data", data_o, {exp_addr[(n / 4) % 3], 8'(n % 4)});
        chk("wrap_last", last_o, (n == 11) ? 1 : 0);
        n++;
      end
      if (done_o) ndone++;
    end
    chk("wrap_count", n, 12);
    chk("wrap_reads", naddr, 3);
    chk("wrap_done_seen", ndone, 1);
    tick();
    chk("wrap_single_done", done_o, 0);

    start_i = 1; base_addr_i = 7; num_rows_i = 0;
    tick();
    start_i = 0;
    chk("zero_done", done_o, 1);
    chk("zero_cenb", ob_mem_cenb_o, 1);
    chk("zero_valid", valid_o, 0);
    tick();
    chk("zero_done_clr", done_o, 0);
    chk("zero_busy", busy_o, 0);

    start_i = 1; base_addr_i = 5; num_rows_i = 1; ready_i = 1;
    tick();
    start_i = 0;
    tick(); tick(); tick();
    chk("ab_d1", data_o, 2);
    rstn_async_i = 0;
    #1;
    chk_reset_outputs("ab");
    tick();
    chk("ab_nodone0", done_o, 0);
    tick();
    chk("ab_nodone1", done_o, 0);
    rstn_async_i = 1;
    tick();
    chk("ab_nodone2", done_o, 0);
    run_basic("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
